// File: rtl/ram_rd_checker_pkg.sv
// Shared types and defaults for the port-B RAM read checker.
package ram_chk_pkg;

   localparam int DEF_ADDR_W     = 10;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_DEPTH      = 1024;
   localparam int DEF_RD_LATENCY = 2;
   localparam int DEF_ERR_CNT_W  = 11;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_e;

   // Write-side pattern: each word holds its own address truncated to data_w bits.
   function automatic logic [31:0] exp_data(input logic [31:0] addr, input int data_w);
      logic [31:0] mask;
      mask = (data_w >= 32) ? '1 : ((32'd1 << data_w) - 32'd1);
      return addr & mask;
   endfunction

endpackage

// File: rtl/ram_rd_checker_if.sv
// Port-B bus of the dual-port RAM as seen from the read checker.
interface ram_rd_checker_if
   import ram_chk_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic [ADDR_W-1:0] address_b;
   logic              wren_b;
   logic [DATA_W-1:0] q_b;

   modport master (output address_b, output wren_b, input q_b);
   modport slave  (input address_b, input wren_b, output q_b);
endinterface

// File: rtl/ram_rd_checker_rd_lat_pipe.sv
// Valid+address delay line that lines up each issued address with its RAM read data.
module rd_lat_pipe
   import ram_chk_pkg::*;
#(
   parameter int LAT    = DEF_RD_LATENCY,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr
);

   logic [LAT-1:0]    vld_q, vld_d;
   logic [ADDR_W-1:0] addr_q [LAT];
   logic [ADDR_W-1:0] addr_d [LAT];

   // Shift one stage per cycle; a flush only kills the valid bits.
   always_comb begin
      addr_d[0] = in_addr;
      vld_d[0]  = in_valid;
      for (int s = 1; s < LAT; s++) begin
         addr_d[s] = addr_q[s-1];
         vld_d[s]  = vld_q[s-1];
      end
      if (flush) begin
         vld_d = '0;
      end
   end

   // Stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: only a few registers, so every stage is reset; a real RAM array would not be.
         vld_q  <= '0;
         addr_q <= '{default: '0};
      end else begin
         // NOTE: non-blocking so each stage samples its neighbour's pre-edge value.
         vld_q  <= vld_d;
         addr_q <= addr_d;
      end
   end

   assign out_valid = vld_q[LAT-1];
   assign out_addr  = addr_q[LAT-1];

endmodule

// File: rtl/ram_rd_checker.sv
// Sweeps RAM port B, compares each word with data = address and reports the result.
// Optional: define RAM_CHK_ERR_STOP_EN to stop the scan at the first mismatch.
module ram_rd_checker
   import ram_chk_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int RD_LATENCY = DEF_RD_LATENCY,
   parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
   input  logic                 rdclk,
   input  logic                 rst_n,
   input  logic                 start,
   ram_rd_checker_if.master     ram,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [ADDR_W-1:0]    first_err_addr,
   output logic [DATA_W-1:0]    first_err_data
);

   state_e                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [2:0]            drain_cnt_q, drain_cnt_d;
   logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0]     first_err_addr_q, first_err_addr_d;
   logic [DATA_W-1:0]     first_err_data_q, first_err_data_d;
   logic                  pass_q, pass_d;

   logic                  pipe_in_valid;
   logic                  pipe_flush;
   logic                  pipe_out_valid;
   logic [ADDR_W-1:0]     pipe_out_addr;
   logic [31:0]           exp_full;
   logic [DATA_W-1:0]     exp_word;
   logic                  last_addr;
   logic                  mismatch;
   logic                  stop_hit;

   rd_lat_pipe #(
      .LAT    (RD_LATENCY),
      .ADDR_W (ADDR_W)
   ) u_pipe (
      .clk       (rdclk),
      .rst_n     (rst_n),
      .flush     (pipe_flush),
      .in_valid  (pipe_in_valid),
      .in_addr   (addr_q),
      .out_valid (pipe_out_valid),
      .out_addr  (pipe_out_addr)
   );

   assign exp_full  = exp_data(32'(pipe_out_addr), DATA_W);
   assign exp_word  = exp_full[DATA_W-1:0];
   assign last_addr = (addr_q == ADDR_W'(DEPTH - 1));
   assign mismatch  = pipe_out_valid && (state_q == ISSUE || state_q == DRAIN)
                      && (ram.q_b != exp_word);
`ifdef RAM_CHK_ERR_STOP_EN
   assign stop_hit  = mismatch;
`else
   assign stop_hit  = 1'b0;
`endif

   // State register.
   always_ff @(posedge rdclk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = ISSUE;
         ISSUE:   if (stop_hit) state_d = DONE;
                  else if (last_addr) state_d = DRAIN;
         DRAIN:   if (stop_hit || drain_cnt_q == 3'd0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address counter, drain counter and compare bookkeeping.
   always_comb begin
      // NOTE: every target gets a hold default first so no path infers a latch.
      addr_d           = addr_q;
      drain_cnt_d      = drain_cnt_q;
      err_cnt_d        = err_cnt_q;
      first_err_addr_d = first_err_addr_q;
      first_err_data_d = first_err_data_q;
      pass_d           = pass_q;
      pipe_in_valid    = (state_q == ISSUE) && !stop_hit;
      pipe_flush       = stop_hit;

      unique case (state_q)
         IDLE: begin
            addr_d = '0;
            if (start) begin
               err_cnt_d        = '0;
               first_err_addr_d = '0;
               first_err_data_d = '0;
               pass_d           = 1'b0;
            end
         end
         ISSUE: begin
            addr_d      = (last_addr || stop_hit) ? '0 : addr_q + ADDR_W'(1);
            drain_cnt_d = 3'(RD_LATENCY - 1);
         end
         DRAIN: begin
            if (drain_cnt_q != 3'd0) drain_cnt_d = drain_cnt_q - 3'd1;
         end
         default: ;
      endcase

      if (mismatch) begin
         if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
         if (err_cnt_q == '0) begin
            first_err_addr_d = pipe_out_addr;
            first_err_data_d = ram.q_b;
         end
      end

      // Verdict is taken on entry to DONE so it includes the final compare.
      if (state_d == DONE && state_q != DONE) pass_d = (err_cnt_d == '0);
   end

   // Datapath registers.
   always_ff @(posedge rdclk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q           <= '0;
         drain_cnt_q      <= '0;
         err_cnt_q        <= '0;
         first_err_addr_q <= '0;
         first_err_data_q <= '0;
         pass_q           <= 1'b0;
      end else begin
         addr_q           <= addr_d;
         drain_cnt_q      <= drain_cnt_d;
         err_cnt_q        <= err_cnt_d;
         first_err_addr_q <= first_err_addr_d;
         first_err_data_q <= first_err_data_d;
         pass_q           <= pass_d;
      end
   end

   // Outputs decoded from state and registers.
   always_comb begin
      busy           = (state_q == ISSUE) || (state_q == DRAIN);
      done           = (state_q == DONE);
      ram.address_b  = addr_q;
      ram.wren_b     = 1'b0;
      pass           = pass_q;
      err_cnt        = err_cnt_q;
      first_err_addr = first_err_addr_q;
      first_err_data = first_err_data_q;
   end

endmodule

// File: tb/tb_ram_rd_checker.sv
// Self-checking bench for ram_rd_checker: two DUTs (read latency 2 and 1) on one RAM image.
module tb_ram_rd_checker;

   localparam int DEPTH = 1024;

   typedef enum {C_NONE, C_TWO, C_ALL, C_ONE10} corrupt_e;

   typedef struct {
      int       lat;
      corrupt_e corrupt;
      bit       extra;
      int       done_off;
      bit       pass;
      int       err;
      int       faddr;
      int       fdata;
      int       issue_len;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic sel = 1'b0;
   int   edge_n = 0;
   int   checks = 0;
   int   failures = 0;
   int   wren_err = 0;

   logic        busy0, done0, pass0, busy1, done1, pass1;
   logic [10:0] err0, err1;
   logic [9:0]  fa0, fa1;
   logic [7:0]  fd0, fd1;

   ram_rd_checker_if #(.ADDR_W(10), .DATA_W(8)) if0 ();
   ram_rd_checker_if #(.ADDR_W(10), .DATA_W(8)) if1 ();

   ram_rd_checker #(.RD_LATENCY(2)) u_dut0 (
      .rdclk(clk), .rst_n(rst_n), .start(start0), .ram(if0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
      .first_err_addr(fa0), .first_err_data(fd0)
   );

   ram_rd_checker #(.RD_LATENCY(1)) u_dut1 (
      .rdclk(clk), .rst_n(rst_n), .start(start1), .ram(if1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
      .first_err_addr(fa1), .first_err_data(fd1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   // RAM image and its two read ports (latency 2 and 1).
   logic [7:0] mem [DEPTH];
   logic [7:0] r0_s1, r0_s2, r1_s1;
   always @(posedge clk) begin
      r0_s1 <= mem[if0.address_b];
      r0_s2 <= r0_s1;
      r1_s1 <= mem[if1.address_b];
   end
   assign if0.q_b = r0_s2;
   assign if1.q_b = r1_s1;

   always @(negedge clk) if (if0.wren_b !== 1'b0 || if1.wren_b !== 1'b0) wren_err++;

   logic [9:0]  obs_addr;
   logic        obs_busy, obs_done, obs_pass;
   logic [10:0] obs_err;
   logic [9:0]  obs_fa;
   logic [7:0]  obs_fd;
   assign obs_addr = sel ? if1.address_b : if0.address_b;
   assign obs_busy = sel ? busy1 : busy0;
   assign obs_done = sel ? done1 : done0;
   assign obs_pass = sel ? pass1 : pass0;
   assign obs_err  = sel ? err1  : err0;
   assign obs_fa   = sel ? fa1   : fa0;
   assign obs_fd   = sel ? fd1   : fd0;

   vec_t vecs [5];
   vec_t sb_q [$];

`ifdef RAM_CHK_ERR_STOP_EN
   localparam corrupt_e MID_CORRUPT = C_NONE;
`else
   localparam corrupt_e MID_CORRUPT = C_TWO;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_addr"}, 32'(obs_addr), 0);
      check({tag, "_busy"}, 32'(obs_busy), 0);
      check({tag, "_done"}, 32'(obs_done), 0);
      check({tag, "_pass"}, 32'(obs_pass), 0);
      check({tag, "_err"},  32'(obs_err),  0);
      check({tag, "_fa"},   32'(obs_fa),   0);
      check({tag, "_fd"},   32'(obs_fd),   0);
   endtask

   task automatic preload(input corrupt_e c);
      for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a);
      case (c)
         C_TWO:   begin mem[5] = 8'hFF; mem[700] = 8'h00; end
         C_ALL:   for (int a = 0; a < DEPTH; a++) mem[a] = ~8'(a);
         C_ONE10: mem[10] = 8'h55;
         default: ;
      endcase
   endtask

   task automatic set_start(input logic b);
      if (sel) start1 = b;
      else     start0 = b;
   endtask

   task automatic run_scan(input int vi);
      vec_t v, e;
      int   k, c, idx, exp_addr, done_cnt, done_at, seq_err;
      logic exp_busy;
      v = vecs[vi];
      sel = (v.lat == 1);
      preload(v.corrupt);
      sb_q.push_back(v);
      @(negedge clk);
      set_start(1'b1);
      k = edge_n + 1;
      done_cnt = 0; done_at = -1; seq_err = 0;
      for (int n = 0; n < v.done_off + 2; n++) begin
         @(negedge clk);
         c = edge_n + 1;
         set_start(v.extra && (c == k + 3 || c == k + 500));
         idx = c - k - 1;
         exp_addr = (idx < v.issue_len) ? idx : 0;
         exp_busy = (c < k + v.done_off);
         if (obs_addr !== 10'(exp_addr)) seq_err++;
         if (obs_busy !== exp_busy) seq_err++;
         if (exp_busy && obs_pass !== 1'b0) seq_err++;
         if (obs_done) begin
            done_cnt++;
            done_at = c - k;
            if (sb_q.size() == 0) begin
               check($sformatf("v%0d_sb_empty", vi), 1, 0);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("v%0d_pass", vi),  32'(obs_pass), 32'(e.pass));
               check($sformatf("v%0d_err", vi),   32'(obs_err),  e.err);
               check($sformatf("v%0d_faddr", vi), 32'(obs_fa),   e.faddr);
               check($sformatf("v%0d_fdata", vi), 32'(obs_fd),   e.fdata);
            end
         end
      end
      set_start(1'b0);
      check($sformatf("v%0d_done_pulses", vi), done_cnt, 1);
      check($sformatf("v%0d_done_cycle", vi), done_at, v.done_off);
      check($sformatf("v%0d_sequence", vi), seq_err, 0);
      check($sformatf("v%0d_hold_err", vi), 32'(obs_err), v.err);
      check($sformatf("v%0d_hold_pass", vi), 32'(obs_pass), 32'(v.pass));
      while (sb_q.size() > 0) void'(sb_q.pop_front());
   endtask

   initial begin
      int reached;
      //          lat corrupt  extra off   pass err   fa  fd     issue
`ifdef RAM_CHK_ERR_STOP_EN
      vecs[0] = '{2, C_NONE,  1'b1, 1027, 1'b1, 0,    0,  0,     1024};
      vecs[1] = '{2, C_TWO,   1'b0, 9,    1'b0, 1,    5,  8'hFF, 8};
      vecs[2] = '{2, C_ALL,   1'b0, 4,    1'b0, 1,    0,  8'hFF, 3};
      vecs[3] = '{2, C_ONE10, 1'b0, 14,   1'b0, 1,    10, 8'h55, 13};
`else
      vecs[0] = '{2, C_NONE,  1'b1, 1027, 1'b1, 0,    0,  0,     1024};
      vecs[1] = '{2, C_TWO,   1'b0, 1027, 1'b0, 2,    5,  8'hFF, 1024};
      vecs[2] = '{2, C_ALL,   1'b0, 1027, 1'b0, 1024, 0,  8'hFF, 1024};
      vecs[3] = '{2, C_ONE10, 1'b0, 1027, 1'b0, 1,    10, 8'h55, 1024};
`endif
      vecs[4] = '{1, C_NONE,  1'b0, 1026, 1'b1, 0,    0,  0,     1024};

      // Reset with start toggling on both DUTs.
      preload(C_NONE);
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start0 = i[0];
         start1 = i[0];
      end
      sel = 1'b0; check_zero("rst0");
      sel = 1'b1; check_zero("rst1");
      start0 = 1'b0; start1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      sel = 1'b0;
      check("post_rst_addr0", 32'(obs_addr), 0);
      check("post_rst_busy0", 32'(obs_busy), 0);
      sel = 1'b1;
      check("post_rst_addr1", 32'(obs_addr), 0);
      check("post_rst_busy1", 32'(obs_busy), 0);

      for (int vi = 0; vi < 5; vi++) run_scan(vi);

      // Reset in the middle of a scan, at address 300.
      sel = 1'b0;
      preload(MID_CORRUPT);
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      reached = 0;
      for (int n = 0; n < 400 && reached == 0; n++) begin
         @(negedge clk);
         if (obs_addr == 10'd300) reached = 1;
      end
      check("mid_reach_300", reached, 1);
      rst_n = 1'b0;
      #1;
      check_zero("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_post_busy", 32'(obs_busy), 0);
      run_scan(0);

      check("wren_low", wren_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
